stencil_access_scheduler: RTL and testbench

Sequences and arbitrates all accesses to the stencil cache. It shares the cache between two requesters: the rasterizer, which issues per-pixel pair-mode reads and writes, and the bulk engine, which issues 16-pixel full-mode reads and writes for VRAM upload, copy and fill. It also owns a built-in clear sequencer. It sits between those requesters and the cache, drives every cache control input, enforces the cache's bank and pair conflict rules, and returns read data one cycle after grant.

---
 rtl/stencil_access_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_stencil_access_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stencil_access_scheduler.sv
// Stencil cache access scheduler: arbitrates rasterizer pair-mode and bulk
// full-mode traffic onto the single cache port, and runs a full-cache clear.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | normal arbitration between rasterizer and bulk requesters
//   S_CLEAR | clear sequencer owns the cache, one full-mode write per cycle
module stencil_access_scheduler #(
  parameter logic [14:0] CLEAR_LAST  = 15'h7FFF,
  parameter logic        CLEAR_VALUE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  // rasterizer read
  input  logic        rast_rd_req,
  input  logic [14:0] rast_rd_adr,
  input  logic [2:0]  rast_rd_pair,
  input  logic [1:0]  rast_rd_sel,
  output logic        rast_rd_ack,
  output logic        rast_rd_valid,
  output logic [1:0]  rast_rd_value,
  // rasterizer write
  input  logic        rast_wr_req,
  input  logic [14:0] rast_wr_adr,
  input  logic [2:0]  rast_wr_pair,
  input  logic [1:0]  rast_wr_sel,
  input  logic [1:0]  rast_wr_value,
  output logic        rast_wr_ack,
  // bulk engine
  input  logic        bulk_req,
  input  logic        bulk_we,
  input  logic [14:0] bulk_adr,
  input  logic [15:0] bulk_wdata,
  input  logic [15:0] bulk_wmask,
  output logic        bulk_ack,
  output logic        bulk_rvalid,
  output logic [15:0] bulk_rdata,
  // clear sequencer
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        clear_done,
  // cache port
  output logic        st_fullMode,
  output logic        st_writeSig,
  output logic [14:0] st_writeAdr,
  output logic [2:0]  st_writePair,
  output logic [1:0]  st_writeSelect,
  output logic [1:0]  st_writeValue,
  output logic [15:0] st_writeValue16,
  output logic [15:0] st_writeMask16,
  output logic        st_readSig,
  output logic [14:0] st_readAdr,
  output logic [2:0]  st_readPair,
  output logic [1:0]  st_readSelect,
  input  logic [15:0] st_readValue16,
  input  logic [1:0]  st_readValue
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;            // 0: rasterizer wins next contended cycle
  logic [14:0] cnt_q, cnt_d;
  logic        ret_valid_q, ret_valid_d;
  logic        ret_bulk_q, ret_bulk_d; // side that owns the returning read
  logic        done_q, done_d;

  logic rast_any, rast_own, bulk_own, rd_conflict;

  // State, round-robin, clear counter and read-return registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      ret_valid_q <= 1'b0;
      ret_bulk_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      ret_valid_q <= ret_valid_d;
      ret_bulk_q  <= ret_bulk_d;
      done_q      <= done_d;
    end
  end

  // Owner selection, cache port drive, acks and next-state.
  always_comb begin
    state_d         = state_q;
    rr_d            = rr_q;
    cnt_d           = cnt_q;
    ret_valid_d     = 1'b0;
    ret_bulk_d      = ret_bulk_q;
    done_d          = 1'b0;
    rast_rd_ack     = 1'b0;
    rast_wr_ack     = 1'b0;
    bulk_ack        = 1'b0;
    clear_busy      = 1'b0;
    st_fullMode     = 1'b0;
    st_writeSig     = 1'b0;
    st_writeAdr     = '0;
    st_writePair    = '0;
    st_writeSelect  = '0;
    st_writeValue   = '0;
    st_writeValue16 = '0;
    st_writeMask16  = '0;
    st_readSig      = 1'b0;
    st_readAdr      = '0;
    st_readPair     = '0;
    st_readSelect   = '0;

    rast_any    = rast_rd_req | rast_wr_req;
    rast_own    = rast_any & (~bulk_req | ~rr_q);
    bulk_own    = bulk_req & (~rast_any | rr_q);
    // The cache cannot serve a read and a write of the same pair in one bank.
    rd_conflict = rast_wr_req & (rast_rd_adr[6] == rast_wr_adr[6]) &
                  (rast_rd_pair == rast_wr_pair);

    case (state_q)
      S_IDLE: begin
        if (!rst) begin
          if (rast_any && bulk_req) begin
            rr_d = rast_own; // hand priority to whoever lost this cycle
          end
          if (rast_own) begin
            if (rast_wr_req) begin
              rast_wr_ack    = 1'b1;
              st_writeSig    = 1'b1;
              st_writeAdr    = rast_wr_adr;
              st_writePair   = rast_wr_pair;
              st_writeSelect = rast_wr_sel;
              st_writeValue  = rast_wr_value;
            end
            if (rast_rd_req && !rd_conflict) begin
              rast_rd_ack   = 1'b1;
              st_readSig    = 1'b1;
              st_readAdr    = rast_rd_adr;
              st_readPair   = rast_rd_pair;
              st_readSelect = rast_rd_sel;
              ret_valid_d   = 1'b1;
              ret_bulk_d    = 1'b0;
            end
          end else if (bulk_own) begin
            bulk_ack    = 1'b1;
            st_fullMode = 1'b1;
            if (bulk_we) begin
              st_writeSig     = 1'b1;
              st_writeAdr     = bulk_adr;
              st_writeValue16 = bulk_wdata;
              st_writeMask16  = bulk_wmask;
            end else begin
              st_readSig  = 1'b1;
              st_readAdr  = bulk_adr;
              ret_valid_d = 1'b1;
              ret_bulk_d  = 1'b1;
            end
          end
          if (clear_start) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end
        end
      end
      S_CLEAR: begin
        clear_busy      = 1'b1;
        st_fullMode     = 1'b1;
        st_writeSig     = 1'b1;
        st_writeAdr     = cnt_q;
        st_writeValue16 = {16{CLEAR_VALUE}};
        st_writeMask16  = 16'hFFFF;
        if (cnt_q == CLEAR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 15'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is passed straight through from the cache in the return cycle.
  always_comb begin
    rast_rd_valid = ret_valid_q & ~ret_bulk_q;
    bulk_rvalid   = ret_valid_q & ret_bulk_q;
    rast_rd_value = rast_rd_valid ? st_readValue : 2'b00;
    bulk_rdata    = bulk_rvalid ? st_readValue16 : 16'h0000;
    clear_done    = done_q;
  end

endmodule

// File: tb/tb_stencil_access_scheduler.sv
// Bench for stencil_access_scheduler with a behavioural stencil cache model.
module tb_stencil_access_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        rast_rd_req, rast_rd_ack, rast_rd_valid;
  logic [14:0] rast_rd_adr;
  logic [2:0]  rast_rd_pair;
  logic [1:0]  rast_rd_sel, rast_rd_value;
  logic        rast_wr_req, rast_wr_ack;
  logic [14:0] rast_wr_adr;
  logic [2:0]  rast_wr_pair;
  logic [1:0]  rast_wr_sel, rast_wr_value;
  logic        bulk_req, bulk_we, bulk_ack, bulk_rvalid;
  logic [14:0] bulk_adr;
  logic [15:0] bulk_wdata, bulk_wmask, bulk_rdata;
  logic        clear_start, clear_busy, clear_done;
  logic        st_fullMode, st_writeSig, st_readSig;
  logic [14:0] st_writeAdr, st_readAdr;
  logic [2:0]  st_writePair, st_readPair;
  logic [1:0]  st_writeSelect, st_writeValue, st_readSelect;
  logic [15:0] st_writeValue16, st_writeMask16;
  logic [15:0] st_readValue16;
  logic [1:0]  st_readValue;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stencil_access_scheduler #(.CLEAR_LAST(15'h000F), .CLEAR_VALUE(1'b0)) dut (
    .clk(clk), .rst(rst),
    .rast_rd_req(rast_rd_req), .rast_rd_adr(rast_rd_adr), .rast_rd_pair(rast_rd_pair),
    .rast_rd_sel(rast_rd_sel), .rast_rd_ack(rast_rd_ack), .rast_rd_valid(rast_rd_valid),
    .rast_rd_value(rast_rd_value),
    .rast_wr_req(rast_wr_req), .rast_wr_adr(rast_wr_adr), .rast_wr_pair(rast_wr_pair),
    .rast_wr_sel(rast_wr_sel), .rast_wr_value(rast_wr_value), .rast_wr_ack(rast_wr_ack),
    .bulk_req(bulk_req), .bulk_we(bulk_we), .bulk_adr(bulk_adr), .bulk_wdata(bulk_wdata),
    .bulk_wmask(bulk_wmask), .bulk_ack(bulk_ack), .bulk_rvalid(bulk_rvalid),
    .bulk_rdata(bulk_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .st_fullMode(st_fullMode), .st_writeSig(st_writeSig), .st_writeAdr(st_writeAdr),
    .st_writePair(st_writePair), .st_writeSelect(st_writeSelect),
    .st_writeValue(st_writeValue), .st_writeValue16(st_writeValue16),
    .st_writeMask16(st_writeMask16), .st_readSig(st_readSig), .st_readAdr(st_readAdr),
    .st_readPair(st_readPair), .st_readSelect(st_readSelect),
    .st_readValue16(st_readValue16), .st_readValue(st_readValue)
  );

  // Stencil cache model: 16 bits per block, 8 pairs of 2 pixels.
  logic [15:0] mem [0:32767];

  // Cache model: writes update the block, reads return data one cycle later.
  always @(posedge clk) begin
    logic [15:0] w;
    if (st_readSig) begin
      st_readValue16 <= mem[st_readAdr];
      st_readValue   <= mem[st_readAdr][2*st_readPair +: 2];
    end
    if (st_writeSig) begin
      w = mem[st_writeAdr];
      if (st_fullMode) begin
        w = (w & ~st_writeMask16) | (st_writeValue16 & st_writeMask16);
      end else begin
        if (st_writeSelect[0]) w[2*st_writePair]     = st_writeValue[0];
        if (st_writeSelect[1]) w[2*st_writePair + 1] = st_writeValue[1];
      end
      mem[st_writeAdr] <= w;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rast_rd_req = 0; rast_rd_adr = 0; rast_rd_pair = 0; rast_rd_sel = 2'b11;
    rast_wr_req = 0; rast_wr_adr = 0; rast_wr_pair = 0; rast_wr_sel = 2'b11;
    rast_wr_value = 2'b10;
    bulk_req = 0; bulk_we = 0; bulk_adr = 0; bulk_wdata = 0; bulk_wmask = 0;
    clear_start = 0;
  endtask

  // One bulk transaction; for reads the returned block is checked.
  task automatic bulk_op(input logic we, input logic [14:0] adr, input logic [15:0] d,
                         input logic [15:0] m, input logic [15:0] exp_rd, input string name);
    @(posedge clk); #1;
    bulk_req = 1; bulk_we = we; bulk_adr = adr; bulk_wdata = d; bulk_wmask = m;
    #3 chk({name, "_ack"}, bulk_ack, 1);
    @(posedge clk); #1;
    bulk_req = 0;
    #3;
    if (!we) begin
      chk({name, "_rvalid"}, bulk_rvalid, 1);
      chk({name, "_rdata"}, bulk_rdata, exp_rd);
    end
  endtask

  typedef struct packed {
    logic        rrd, rwr, brq, bwe;
    logic [14:0] rd_adr;
    logic [2:0]  rd_pair;
    logic [14:0] wr_adr;
    logic [2:0]  wr_pair;
    logic        e_rd, e_wr, e_bk, e_fm, e_ws, e_rs;
  } vec_t;

  vec_t vecs [13];

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    st_readValue16 = 0; st_readValue = 0;

    //         rrd rwr brq bwe rd_adr    rp   wr_adr    wp   rd wr bk fm ws rs
    vecs[0]  = '{0, 0, 0, 0, 15'h0000, 3'd0, 15'h0000, 3'd0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 15'h0000, 3'd0, 15'h0040, 3'd3, 0, 1, 0, 0, 1, 0};
    vecs[2]  = '{1, 1, 0, 0, 15'h0000, 3'd3, 15'h0040, 3'd3, 1, 1, 0, 0, 1, 1};
    vecs[3]  = '{1, 1, 0, 0, 15'h0040, 3'd3, 15'h0040, 3'd3, 0, 1, 0, 0, 1, 0};
    vecs[4]  = '{1, 0, 0, 0, 15'h0040, 3'd3, 15'h0000, 3'd0, 1, 0, 0, 0, 0, 1};
    vecs[5]  = '{0, 1, 1, 1, 15'h0000, 3'd0, 15'h0040, 3'd3, 0, 1, 0, 0, 1, 0};
    vecs[6]  = '{0, 1, 1, 1, 15'h0000, 3'd0, 15'h0040, 3'd3, 0, 0, 1, 1, 1, 0};
    vecs[7]  = '{0, 1, 1, 1, 15'h0000, 3'd0, 15'h0040, 3'd3, 0, 1, 0, 0, 1, 0};
    vecs[8]  = '{0, 0, 1, 0, 15'h0000, 3'd0, 15'h0000, 3'd0, 0, 0, 1, 1, 0, 1};
    vecs[9]  = '{1, 0, 0, 0, 15'h0040, 3'd3, 15'h0000, 3'd0, 1, 0, 0, 0, 0, 1};
    vecs[10] = '{1, 0, 1, 1, 15'h0040, 3'd3, 15'h0000, 3'd0, 0, 0, 1, 1, 1, 0};
    vecs[11] = '{1, 0, 1, 1, 15'h0040, 3'd3, 15'h0000, 3'd0, 1, 0, 0, 0, 0, 1};
    vecs[12] = '{1, 1, 0, 0, 15'h0040, 3'd2, 15'h0040, 3'd3, 1, 1, 0, 0, 1, 1};

    idle_inputs();
    rst = 1;
    #2;
    chk("reset_outputs", {rast_rd_ack, rast_rd_valid, rast_rd_value, rast_wr_ack, bulk_ack,
                          bulk_rvalid, clear_busy, clear_done, st_fullMode, st_writeSig,
                          st_readSig, st_writeMask16}, 0);
    chk("reset_bulk_rdata", bulk_rdata, 0);
    chk("reset_st_adr", {st_writeAdr, st_readAdr}, 0);
    @(posedge clk); @(posedge clk); #1 rst = 0;

    // Single-cycle arbitration vectors; rr starts at 0 after reset.
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      rast_rd_req = vecs[i].rrd; rast_rd_adr = vecs[i].rd_adr; rast_rd_pair = vecs[i].rd_pair;
      rast_wr_req = vecs[i].rwr; rast_wr_adr = vecs[i].wr_adr; rast_wr_pair = vecs[i].wr_pair;
      bulk_req = vecs[i].brq; bulk_we = vecs[i].bwe; bulk_adr = 15'h0200;
      bulk_wdata = 16'hFFFF; bulk_wmask = 16'h0000;
      #3;
      chk($sformatf("vec%0d_acks", i), {rast_rd_ack, rast_wr_ack, bulk_ack},
          {vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_bk});
      chk($sformatf("vec%0d_port", i), {st_fullMode, st_writeSig, st_readSig},
          {vecs[i].e_fm, vecs[i].e_ws, vecs[i].e_rs});
    end
    @(posedge clk); #1 idle_inputs();

    // Read back the pair written earlier: data one cycle after ack.
    @(posedge clk); #1;
    rast_rd_req = 1; rast_rd_adr = 15'h0040; rast_rd_pair = 3'd3;
    #3 chk("rd_ack", rast_rd_ack, 1);
    chk("rd_valid_not_yet", rast_rd_valid, 0);
    @(posedge clk); #1 rast_rd_req = 0;
    #3 chk("rd_valid", rast_rd_valid, 1);
    chk("rd_value", rast_rd_value, 2'b10);
    @(posedge clk); #4 chk("rd_valid_drop", rast_rd_valid, 0);

    // Masked bulk write keeps the upper byte.
    bulk_op(1, 15'h0100, 16'h1234, 16'hFFFF, 16'h0, "bulk_wr_full");
    bulk_op(1, 15'h0100, 16'hA5A5, 16'h00FF, 16'h0, "bulk_wr_mask");
    bulk_op(0, 15'h0100, 16'h0, 16'h0, 16'h12A5, "bulk_rd_mask");
    bulk_op(1, 15'h0005, 16'hFFFF, 16'hFFFF, 16'h0, "bulk_wr_pre");
    bulk_op(1, 15'h000F, 16'hF0F0, 16'hFFFF, 16'h0, "bulk_wr_pre2");

    // Clear with a rasterizer read pending in the start cycle.
    @(posedge clk); #1;
    clear_start = 1; rast_rd_req = 1; rast_rd_adr = 15'h0040; rast_rd_pair = 3'd3;
    #3 chk("clr_start_rd_ack", rast_rd_ack, 1);
    chk("clr_start_busy", clear_busy, 0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      clear_start = (i == 3); // ignored while busy
      rast_rd_req = 0;
      rast_wr_req = 1; rast_wr_adr = 15'h0003;
      bulk_req = 1; bulk_we = 1; bulk_adr = 15'h0003; bulk_wdata = 16'h5555;
      bulk_wmask = 16'hFFFF;
      #3;
      if (i == 0) begin
        chk("clr_rd_return_valid", rast_rd_valid, 1);
        chk("clr_rd_return_value", rast_rd_value, 2'b10);
      end
      chk($sformatf("clr%0d_busy", i), clear_busy, 1);
      chk($sformatf("clr%0d_acks", i), {rast_rd_ack, rast_wr_ack, bulk_ack}, 0);
      chk($sformatf("clr%0d_port", i), {st_fullMode, st_writeSig, st_writeAdr, st_writeMask16,
                                         clear_done}, {1'b1, 1'b1, 15'(i), 16'hFFFF, 1'b0});
    end
    @(posedge clk); #1 idle_inputs();
    #3 chk("clr_done_pulse", {clear_done, clear_busy}, 2'b10);
    @(posedge clk); #4 chk("clr_done_drop", {clear_done, clear_busy}, 2'b00);
    bulk_op(0, 15'h0005, 16'h0, 16'h0, 16'h0000, "clr_rd_5");
    bulk_op(0, 15'h000F, 16'h0, 16'h0, 16'h0000, "clr_rd_F");
    bulk_op(0, 15'h0003, 16'h0, 16'h0, 16'h0000, "clr_rd_3");
    bulk_op(0, 15'h0100, 16'h0, 16'h0, 16'h12A5, "clr_rd_outside");

    // Reset in the middle of a clear.
    @(posedge clk); #1 clear_start = 1;
    @(posedge clk); #1 clear_start = 0;
    repeat (4) @(posedge clk);
    #1 chk("midclr_busy", clear_busy, 1);
    rst = 1;
    #1 chk("midclr_rst_busy", {clear_busy, clear_done, st_writeSig}, 0);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 3; i++) begin
      #3 chk($sformatf("midclr_nodone%0d", i), {clear_done, clear_busy}, 0);
      @(posedge clk); #1;
    end

    // Continuous contention after reset alternates, rasterizer first.
    rast_wr_req = 1; rast_wr_adr = 15'h0040; rast_wr_pair = 3'd3;
    bulk_req = 1; bulk_we = 1; bulk_adr = 15'h0200; bulk_wmask = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      #3;
      chk($sformatf("alt%0d_acks", i), {rast_wr_ack, bulk_ack, st_fullMode},
          (i % 2 == 0) ? 3'b100 : 3'b011);
      @(posedge clk); #1;
    end
    idle_inputs();

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
